// File: rtl/rom_fetch_master_pkg.sv
// Purpose : shared types and constants for the ROM fetch master.
// Latency : n/a (declarations only).
// Backpres: n/a.
// Holds the FSM encoding, active-low strobe levels, reset level, the NOP word
// and the default ROM geometry.
package rom_fetch_master_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      REQ    = 2'd1,
      ACCESS = 2'd2,
      STALL  = 2'd3
   } state_t;

   // Active-low strobe levels on the ROM side (cs_n, as_n, rdy_n).
   localparam logic ENABLE_  = 1'b0;
   localparam logic DISABLE_ = 1'b1;

   // Level of the synchronous reset input that resets the block.
   localparam logic RESET_ENABLE = 1'b0;

   localparam int ROM_ADDR_W = 11;
   localparam int ROM_DATA_W = 32;

   // Word returned to the fetch stage when the slave times out.
   localparam logic [ROM_DATA_W-1:0] NOP = '0;

endpackage

// File: rtl/fetch_timeout_ctr.sv
// Purpose : clear/count/expire wait counter for the ROM access phase.
// Latency : count registered; expire is a combinational decode of the count.
// Backpres: none; saturates at TIMEOUT-1 rather than wrapping.
// Ports   : clk, reset (sync, active-low), clr (zero the count),
//           cnt (advance by one), expire (count has reached TIMEOUT-1).
module fetch_timeout_ctr
   import rom_fetch_master_pkg::*;
#(
   parameter int TIMEOUT = 15
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic cnt,
   output logic expire
);

   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [TW-1:0] LAST = TW'(TIMEOUT - 1);

   logic [TW-1:0] timer_q;
   logic [TW-1:0] timer_d;

   always_comb begin
      timer_d = timer_q;
      if (clr) begin
         timer_d = '0;
      end else if (cnt && (timer_q != LAST)) begin
         timer_d = timer_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset == RESET_ENABLE) begin
         timer_q <= '0;
      end else begin
         timer_q <= timer_d;
      end
   end

   assign expire = (timer_q == LAST);

endmodule

// File: rtl/rom_fetch_master.sv
// Purpose : turns CPU fetch requests into ROM cs_n/as_n/addr strobes and
//           returns the word read back, with stall, flush and timeout.
// Latency : request sampled in IDLE -> cpu_valid on the 3rd edge with a
//           1-cycle ROM; one word per 3 cycles back to back.
// Backpres: busy (combinational) tells the CPU to stall; cpu_stall holds the
//           delivered word in STALL; slave is never abandoned mid-handshake.
// Ports   : cpu_* fetch-stage side, cs_n/as_n/bus_addr/bus_rd_data/bus_rdy_n
//           ROM side, bus_err one-cycle timeout pulse, busy fetch in progress.
module rom_fetch_master
   import rom_fetch_master_pkg::*;
#(
   parameter int ADDR_W  = ROM_ADDR_W,
   parameter int DATA_W  = ROM_DATA_W,
   parameter int TIMEOUT = 15
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cpu_req,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic              cpu_stall,
   input  logic              cpu_flush,
   output logic [DATA_W-1:0] cpu_rd_data,
   output logic              cpu_valid,
   output logic              busy,
   output logic              bus_err,
   output logic              cs_n,
   output logic              as_n,
   output logic [ADDR_W-1:0] bus_addr,
   input  logic [DATA_W-1:0] bus_rd_data,
   input  logic              bus_rdy_n
);

   state_t              state_q,       state_d;
   logic                cs_n_q,        cs_n_d;
   logic                as_n_q,        as_n_d;
   logic [ADDR_W-1:0]   bus_addr_q,    bus_addr_d;
   logic [DATA_W-1:0]   cpu_rd_data_q, cpu_rd_data_d;
   logic                cpu_valid_q,   cpu_valid_d;
   logic                bus_err_q,     bus_err_d;
   logic                flushed_q,     flushed_d;

   logic tmr_clr;
   logic tmr_cnt;
   logic tmr_expire;

   fetch_timeout_ctr #(
      .TIMEOUT (TIMEOUT)
   ) u_timeout (
      .clk    (clk),
      .reset  (reset),
      .clr    (tmr_clr),
      .cnt    (tmr_cnt),
      .expire (tmr_expire)
   );

   always_comb begin
      state_d       = state_q;
      cs_n_d        = cs_n_q;
      as_n_d        = as_n_q;
      bus_addr_d    = bus_addr_q;
      cpu_rd_data_d = cpu_rd_data_q;
      cpu_valid_d   = cpu_valid_q;
      bus_err_d     = 1'b0;
      flushed_d     = flushed_q;
      tmr_clr       = 1'b0;
      tmr_cnt       = 1'b0;

      case (state_q)
         IDLE: begin
            // Valid is always dropped here so an unstalled delivery is a
            // single cycle even when the next request follows immediately.
            cpu_valid_d = 1'b0;
            if (cpu_req && !cpu_flush) begin
               cs_n_d     = ENABLE_;
               as_n_d     = ENABLE_;
               bus_addr_d = cpu_addr;
               flushed_d  = 1'b0;
               state_d    = REQ;
            end
         end

         REQ: begin
            as_n_d  = DISABLE_;
            tmr_clr = 1'b1;
            if (cpu_flush) begin
               flushed_d = 1'b1;
            end
            state_d = ACCESS;
         end

         ACCESS: begin
            if (cpu_flush) begin
               flushed_d = 1'b1;
            end
            // rdy is checked before the timeout so a reply on the expiry
            // edge still delivers data and raises no bus_err.
            if (bus_rdy_n == ENABLE_) begin
               cs_n_d = DISABLE_;
               if (!flushed_q && !cpu_flush) begin
                  cpu_rd_data_d = bus_rd_data;
                  cpu_valid_d   = 1'b1;
                  state_d       = cpu_stall ? STALL : IDLE;
               end else begin
                  cpu_valid_d = 1'b0;
                  state_d     = IDLE;
               end
            end else if (tmr_expire) begin
               cs_n_d        = DISABLE_;
               bus_err_d     = 1'b1;
               cpu_rd_data_d = DATA_W'(NOP);
               cpu_valid_d   = 1'b0;
               state_d       = IDLE;
            end else begin
               tmr_cnt = 1'b1;
            end
         end

         STALL: begin
            if (!cpu_stall || cpu_flush) begin
               cpu_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset == RESET_ENABLE) begin
         state_q       <= IDLE;
         cs_n_q        <= DISABLE_;
         as_n_q        <= DISABLE_;
         bus_addr_q    <= '0;
         cpu_rd_data_q <= '0;
         cpu_valid_q   <= 1'b0;
         bus_err_q     <= 1'b0;
         flushed_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         cs_n_q        <= cs_n_d;
         as_n_q        <= as_n_d;
         bus_addr_q    <= bus_addr_d;
         cpu_rd_data_q <= cpu_rd_data_d;
         cpu_valid_q   <= cpu_valid_d;
         bus_err_q     <= bus_err_d;
         flushed_q     <= flushed_d;
      end
   end

   assign busy = ((state_q == IDLE) && cpu_req && !cpu_flush)
               || (state_q == REQ) || (state_q == ACCESS);

   assign cpu_rd_data = cpu_rd_data_q;
   assign cpu_valid   = cpu_valid_q;
   assign bus_err     = bus_err_q;
   assign cs_n        = cs_n_q;
   assign as_n        = as_n_q;
   assign bus_addr    = bus_addr_q;

endmodule

// File: tb/tb_rom_fetch_master.sv
// Purpose : directed self-checking bench for rom_fetch_master.
// Latency : checks sampled 1 time unit after each rising edge.
// Backpres: exercises stall, flush, timeout and mid-access reset.
module tb_rom_fetch_master;

   logic        clk;
   logic        reset;
   logic        cpu_req;
   logic [10:0] cpu_addr;
   logic        cpu_stall;
   logic        cpu_flush;
   logic [31:0] cpu_rd_data;
   logic        cpu_valid;
   logic        busy;
   logic        bus_err;
   logic        cs_n;
   logic        as_n;
   logic [10:0] bus_addr;
   logic [31:0] bus_rd_data;
   logic        bus_rdy_n;

   // When set, the ROM answers every as_n sample with rdy_n low on the
   // following cycle carrying word[addr] = 0x1000_0000 + addr.
   logic        rom_auto;

   int n_assert;
   int n_fail;

   rom_fetch_master #(
      .ADDR_W  (11),
      .DATA_W  (32),
      .TIMEOUT (15)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .cpu_req     (cpu_req),
      .cpu_addr    (cpu_addr),
      .cpu_stall   (cpu_stall),
      .cpu_flush   (cpu_flush),
      .cpu_rd_data (cpu_rd_data),
      .cpu_valid   (cpu_valid),
      .busy        (busy),
      .bus_err     (bus_err),
      .cs_n        (cs_n),
      .as_n        (as_n),
      .bus_addr    (bus_addr),
      .bus_rd_data (bus_rd_data),
      .bus_rdy_n   (bus_rdy_n)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      logic        pa;
      logic [10:0] pad;
      pa  = as_n;
      pad = bus_addr;
      @(posedge clk);
      #1;
      if (rom_auto) begin
         if (pa === 1'b0) begin
            bus_rdy_n   = 1'b0;
            bus_rd_data = 32'h1000_0000 + {21'd0, pad};
         end else begin
            bus_rdy_n   = 1'b1;
         end
      end
   endtask

   // Unstalled fetch against the auto ROM: strobe on edge 1, valid on edge 3.
   task automatic fetch_normal(input logic [10:0] a, input string tag);
      cpu_addr = a;
      cpu_req  = 1'b1;
      #1;
      chk({tag, "_busy_req"}, busy, 1);
      tick();
      cpu_req = 1'b0;
      chk({tag, "_as_low"}, as_n, 0);
      chk({tag, "_cs_low"}, cs_n, 0);
      chk({tag, "_addr"}, bus_addr, a);
      tick();
      chk({tag, "_as_one_cycle"}, as_n, 1);
      chk({tag, "_no_early_valid"}, cpu_valid, 0);
      chk({tag, "_busy_access"}, busy, 1);
      tick();
      chk({tag, "_valid"}, cpu_valid, 1);
      chk({tag, "_data"}, cpu_rd_data, 32'h1000_0000 + {21'd0, a});
      chk({tag, "_cs_high"}, cs_n, 1);
      chk({tag, "_busy_done"}, busy, 0);
      tick();
      chk({tag, "_valid_one_cycle"}, cpu_valid, 0);
   endtask

   initial begin
      n_assert    = 0;
      n_fail      = 0;
      rom_auto    = 1'b1;
      reset       = 1'b0;
      cpu_req     = 1'b1;
      cpu_addr    = 11'h005;
      cpu_stall   = 1'b0;
      cpu_flush   = 1'b0;
      bus_rd_data = '0;
      bus_rdy_n   = 1'b1;

      // 1. reset held with a pending request
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("rst_cs_n", cs_n, 1);
         chk("rst_as_n", as_n, 1);
         chk("rst_valid", cpu_valid, 0);
         chk("rst_bus_err", bus_err, 0);
      end
      chk("rst_addr", bus_addr, 0);
      chk("rst_data", cpu_rd_data, 0);
      cpu_req = 1'b0;
      reset   = 1'b1;
      #1;
      chk("idle_busy_no_req", busy, 0);

      // 2. single fetch
      fetch_normal(11'h005, "f005");

      // 3. stalled fetch, word held 4 cycles, then normal fetch
      cpu_addr  = 11'h00A;
      cpu_req   = 1'b1;
      cpu_stall = 1'b1;
      tick();
      cpu_req = 1'b0;
      chk("stl_as_low", as_n, 0);
      tick();
      tick();
      chk("stl_valid0", cpu_valid, 1);
      chk("stl_data0", cpu_rd_data, 32'h1000_000A);
      for (int i = 1; i < 4; i++) begin
         tick();
         chk("stl_valid_hold", cpu_valid, 1);
         chk("stl_data_hold", cpu_rd_data, 32'h1000_000A);
         chk("stl_no_strobe", as_n, 1);
      end
      cpu_stall = 1'b0;
      tick();
      chk("stl_release_valid", cpu_valid, 0);
      chk("stl_release_busy", busy, 0);
      fetch_normal(11'h00B, "f00B");

      // 4. flush during ACCESS with a slow ROM
      rom_auto = 1'b0;
      cpu_addr = 11'h003;
      cpu_req  = 1'b1;
      tick();
      cpu_req = 1'b0;
      tick();
      cpu_flush = 1'b1;
      tick();
      cpu_flush = 1'b0;
      chk("fl_cs_held", cs_n, 0);
      chk("fl_busy", busy, 1);
      tick();
      chk("fl_cs_held2", cs_n, 0);
      chk("fl_no_valid", cpu_valid, 0);
      bus_rdy_n   = 1'b0;
      bus_rd_data = 32'h1000_0003;
      tick();
      bus_rdy_n = 1'b1;
      chk("fl_cs_release", cs_n, 1);
      chk("fl_valid_dropped", cpu_valid, 0);
      chk("fl_busy_drop", busy, 0);
      chk("fl_data_kept", cpu_rd_data, 32'h1000_000B);
      tick();
      chk("fl_valid_still0", cpu_valid, 0);

      // 5. slave timeout: ROM never replies
      cpu_addr = 11'h007;
      cpu_req  = 1'b1;
      tick();
      cpu_req = 1'b0;
      tick();                       // ACCESS entered
      for (int i = 0; i < 14; i++) begin
         tick();
         chk("to_no_err_yet", bus_err, 0);
         chk("to_cs_held", cs_n, 0);
      end
      tick();                       // 15th ACCESS edge
      chk("to_bus_err", bus_err, 1);
      chk("to_cs_high", cs_n, 1);
      chk("to_nop", cpu_rd_data, 0);
      chk("to_valid", cpu_valid, 0);
      chk("to_busy", busy, 0);
      tick();
      chk("to_err_pulse", bus_err, 0);
      rom_auto = 1'b1;
      fetch_normal(11'h7FF, "f7FF");

      // rdy on the expiry edge: rdy wins, no bus_err
      rom_auto = 1'b0;
      cpu_addr = 11'h009;
      cpu_req  = 1'b1;
      tick();
      cpu_req = 1'b0;
      tick();
      for (int i = 0; i < 14; i++) begin
         tick();
      end
      bus_rdy_n   = 1'b0;
      bus_rd_data = 32'h1000_0009;
      tick();
      bus_rdy_n = 1'b1;
      chk("race_no_err", bus_err, 0);
      chk("race_valid", cpu_valid, 1);
      chk("race_data", cpu_rd_data, 32'h1000_0009);
      tick();
      chk("race_valid_off", cpu_valid, 0);

      // flush together with a new request in IDLE: request ignored
      cpu_addr  = 11'h010;
      cpu_req   = 1'b1;
      cpu_flush = 1'b1;
      #1;
      chk("fr_busy", busy, 0);
      tick();
      chk("fr_no_strobe", as_n, 1);
      chk("fr_cs", cs_n, 1);
      cpu_req   = 1'b0;
      cpu_flush = 1'b0;

      // 6. reset during ACCESS, late rdy ignored
      cpu_addr = 11'h004;
      cpu_req  = 1'b1;
      tick();
      cpu_req = 1'b0;
      tick();
      chk("mr_in_access", busy, 1);
      reset = 1'b0;
      tick();
      reset = 1'b1;
      chk("mr_cs_n", cs_n, 1);
      chk("mr_as_n", as_n, 1);
      chk("mr_valid", cpu_valid, 0);
      chk("mr_busy", busy, 0);
      bus_rdy_n   = 1'b0;
      bus_rd_data = 32'h1000_0004;
      tick();
      bus_rdy_n = 1'b1;
      chk("mr_late_rdy_valid", cpu_valid, 0);
      chk("mr_late_rdy_data", cpu_rd_data, 0);
      tick();
      chk("mr_late_rdy_valid2", cpu_valid, 0);
      rom_auto = 1'b1;
      fetch_normal(11'h001, "f001");

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
